// File: rtl/conv_pkg.sv
// conv_pkg -- shared constants and types for the conv_mac block.
//   KW   : kernel width/height (3x3 taps)
//   FW   : output frame width/height (19x19 positions)
//   CH   : channels per beat (16)
//   DW   : weight/pixel width (signed 8 bit)
//   ACCW : accumulator / result width (24 bit)
//   state_t : conv_mac control FSM states
package conv_pkg;

    localparam int KW   = 3;
    localparam int FW   = 19;
    localparam int CH   = 16;
    localparam int DW   = 8;
    localparam int ACCW = 24;

    // One w*px product is full precision; 16 of them need 4 more bits.
    localparam int PW   = 2 * DW;
    localparam int SW   = PW + 4;

    localparam int KCW  = $clog2(KW);
    localparam int FCW  = $clog2(FW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac_if.sv
// conv_mac_if -- beat input / result output bundle of conv_mac.
//   start              : one-cycle frame start pulse
//   in_valid/w_data/px_data : input beat, 16 signed 8-bit lanes each
//   out_valid/acc_out/out_X/out_Y : one finished 3x3x16 sum and its position
//   busy, finish       : frame status
//   state              : debug view of the control FSM
//
// Handshake: a beat transfers on a rising clk edge where in_valid=1 and the
// block is in RUN; there is no back-pressure, so in_valid in any other state
// is simply dropped. out_valid is a one-cycle strobe with no ready; the
// consumer must take the result in that cycle.
interface conv_mac_if;
    import conv_pkg::*;

    logic                   start;
    logic                   in_valid;
    logic [CH*DW-1:0]       w_data;
    logic [CH*DW-1:0]       px_data;
    logic                   out_valid;
    logic signed [ACCW-1:0] acc_out;
    logic [FCW-1:0]         out_X;
    logic [FCW-1:0]         out_Y;
    logic                   busy;
    logic                   finish;
    state_t                 state;

    modport master (
        output start, in_valid, w_data, px_data,
        input  out_valid, acc_out, out_X, out_Y, busy, finish, state
    );

    modport slave (
        input  start, in_valid, w_data, px_data,
        output out_valid, acc_out, out_X, out_Y, busy, finish, state
    );

endinterface

// File: rtl/count_n.sv
// count_n -- modulo-MOD up counter.
//   clk, xrst : clock, asynchronous active-low reset
//   enable    : advance by one this edge
//   q         : current count, 0..MOD-1
//   max       : q is at MOD-1 (the next enabled edge wraps to 0)
module count_n #(
    parameter int MOD = 3
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic                   enable,
    output logic [$clog2(MOD)-1:0] q,
    output logic                   max
);

    localparam int            QW   = $clog2(MOD);
    localparam logic [QW-1:0] LAST = QW'(MOD - 1);

    assign max = (q == LAST);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            q <= '0;
        end else if (enable) begin
            q <= max ? '0 : q + QW'(1);
        end
    end

endmodule

// File: rtl/conv_mac.sv
// conv_mac -- 3x3x16 convolution multiply-accumulate over a 19x19 output frame.
//   clk, xrst : clock, asynchronous active-low reset
//   bus       : conv_mac_if.slave (beats in, results and status out)
//
// Beats arrive in order x (innermost), y, X, Y. Pipeline:
//   stage 1 : 16 full-precision products
//   stage 2 : 20-bit sum of the products
//   stage 3 : 24-bit accumulator over the 9 taps; the result is published
//             on the last tap, three cycles after that beat was accepted.
// Valid, first/last-tap flags and X/Y tags travel with the data, so gaps in
// in_valid only create bubbles and never disturb a partial sum.
module conv_mac
    import conv_pkg::*;
(
    input  logic      clk,
    input  logic      xrst,
    conv_mac_if.slave bus
);

    state_t state_q;
    logic   busy_q;

    logic accept;
    logic [KCW-1:0] cnt_x, cnt_y;
    logic [FCW-1:0] pos_x, pos_y;
    logic max_x, max_y, max_px, max_py;
    logic en_y, en_px, en_py, last_beat;

    assign accept    = (state_q == ST_RUN) && bus.in_valid;
    assign en_y      = accept && max_x;
    assign en_px     = en_y && max_y;
    assign en_py     = en_px && max_px;
    assign last_beat = en_py && max_py;

    // A full frame wraps every counter back to 0, and reset clears them, so
    // the chain always reads 0 when a start is honoured.
    count_n #(.MOD(KW)) u_cnt_x (
        .clk(clk), .xrst(xrst), .enable(accept), .q(cnt_x), .max(max_x)
    );
    count_n #(.MOD(KW)) u_cnt_y (
        .clk(clk), .xrst(xrst), .enable(en_y), .q(cnt_y), .max(max_y)
    );
    count_n #(.MOD(FW)) u_cnt_px (
        .clk(clk), .xrst(xrst), .enable(en_px), .q(pos_x), .max(max_px)
    );
    count_n #(.MOD(FW)) u_cnt_py (
        .clk(clk), .xrst(xrst), .enable(en_py), .q(pos_y), .max(max_py)
    );

    // ---------------- stage 1: products ----------------
    logic signed [PW-1:0] prod_d  [CH];
    logic signed [PW-1:0] s1_prod [CH];
    logic                 s1_valid, s1_first, s1_last;
    logic [FCW-1:0]       s1_x, s1_y;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            prod_d[c] = PW'($signed(bus.w_data[DW*c +: DW])) *
                        PW'($signed(bus.px_data[DW*c +: DW]));
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            for (int c = 0; c < CH; c++) begin
                s1_prod[c] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int c = 0; c < CH; c++) begin
                    s1_prod[c] <= prod_d[c];
                end
                s1_first <= (cnt_x == '0) && (cnt_y == '0);
                s1_last  <= max_x && max_y;
                s1_x     <= pos_x;
                s1_y     <= pos_y;
            end
        end
    end

    // ---------------- stage 2: channel sum ----------------
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] s2_sum;
    logic                 s2_valid, s2_first, s2_last;
    logic [FCW-1:0]       s2_x, s2_y;

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < CH; c++) begin
            sum_d = sum_d + SW'(s1_prod[c]);
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= sum_d;
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_x     <= s1_x;
                s2_y     <= s1_y;
            end
        end
    end

    // ---------------- stage 3: tap accumulator ----------------
    // 9 * 16 * 16384 fits in 24 signed bits, so no saturation is needed.
    logic signed [ACCW-1:0] acc_q, acc_next, acc_out_q;
    logic                   out_valid_q, finish_q;
    logic [FCW-1:0]         out_x_q, out_y_q;
    logic                   s2_emit;

    assign acc_next = s2_first ? ACCW'(s2_sum) : acc_q + ACCW'(s2_sum);
    assign s2_emit  = s2_valid && s2_last;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            acc_q       <= '0;
            acc_out_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            out_valid_q <= s2_emit;
            finish_q    <= s2_emit && (s2_x == FCW'(FW - 1)) && (s2_y == FCW'(FW - 1));
            if (s2_valid) begin
                acc_q <= acc_next;
            end
            // Published result fields only move on a completed sum.
            if (s2_emit) begin
                acc_out_q <= acc_next;
                out_x_q   <= s2_x;
                out_y_q   <= s2_y;
            end
        end
    end

    // ---------------- control FSM ----------------
    // DRAIN leaves on the edge after finish, so a start in the finish cycle
    // still sees DRAIN and is dropped.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_beat) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (finish_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.out_X     = out_x_q;
    assign bus.out_Y     = out_y_q;
    assign bus.finish    = finish_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac -- self-checking bench for conv_mac.
// Expected results come from a beat-index model: beat b of a frame sits at
// x=b%3, y=(b/3)%3, X=(b/9)%19, Y=b/171; each output is the sum over its 9
// beats of the 16-lane dot product, due 3 cycles after its last beat.
module tb_conv_mac;
    import conv_pkg::*;

    localparam int FRAME_BEATS = KW * KW * FW * FW;
    localparam int FRAME_OUTS  = FW * FW;
    localparam int EW          = 2 * FCW + ACCW;

    logic clk;
    logic xrst;

    conv_mac_if bus ();

    conv_mac dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int out_cnt     = 0;

    logic [EW-1:0]          exp_q[$];
    int                     exp_cyc_q[$];
    logic signed [ACCW-1:0] last_acc = '0;
    logic [FCW-1:0]         last_x   = '0;
    logic [FCW-1:0]         last_y   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dot(input logic [CH*DW-1:0] w, input logic [CH*DW-1:0] p);
        int  s;
        byte a, b;
        s = 0;
        for (int c = 0; c < CH; c++) begin
            a = w[DW*c +: DW];
            b = p[DW*c +: DW];
            s += int'(a) * int'(b);
        end
        return s;
    endfunction

    // ---------------- monitor ----------------
    logic                   mon_hit, mon_fin;
    logic [EW-1:0]          mon_e;
    logic signed [ACCW-1:0] mon_acc;
    logic [FCW-1:0]         mon_x, mon_y;

    always @(negedge clk) begin
        mon_hit = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        mon_fin = 1'b0;
        mon_e   = '0;
        if (mon_hit) begin
            mon_e   = exp_q[0];
            mon_x   = mon_e[EW-1 -: FCW];
            mon_y   = mon_e[ACCW+FCW-1 -: FCW];
            mon_acc = mon_e[ACCW-1:0];
            mon_fin = (mon_x == FCW'(FW - 1)) && (mon_y == FCW'(FW - 1));
        end
        check("out_valid", bus.out_valid, mon_hit);
        check("finish", bus.finish, mon_fin);
        if (mon_hit) begin
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            check("acc_out", bus.acc_out, mon_acc);
            check("out_X", bus.out_X, mon_x);
            check("out_Y", bus.out_Y, mon_y);
            last_acc = mon_acc;
            last_x   = mon_x;
            last_y   = mon_y;
            out_cnt++;
        end else begin
            check("acc_out_hold", bus.acc_out, last_acc);
            check("out_X_hold", bus.out_X, last_x);
            check("out_Y_hold", bus.out_Y, last_y);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gen_data(input int mode, output logic [CH*DW-1:0] w, output logic [CH*DW-1:0] p);
        case (mode)
            0:       begin w = {CH{8'h01}}; p = {CH{8'h01}}; end
            1:       begin w = {CH{8'h80}}; p = {CH{8'h80}}; end
            2:       begin w = {CH{8'h80}}; p = {CH{8'h7f}}; end
            default: begin
                w = {$urandom, $urandom, $urandom, $urandom};
                p = {$urandom, $urandom, $urandom, $urandom};
            end
        endcase
    endtask

    // Entered and left just after a rising edge. Pulses start, then presents
    // beats until n_beats have been accepted, modelling each one.
    task automatic drive_beats(input int mode, input int gap_pct, input int n_beats, input bit spam_start);
        int b;
        int part;
        int x, y, px, py;
        logic [CH*DW-1:0] w, p;
        b       = 0;
        part    = 0;
        out_cnt = 0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("state_run", bus.state, ST_RUN);
        check("busy_run", bus.busy, 1'b1);
        while (b < n_beats) begin
            gen_data(mode, w, p);
            bus.w_data  = w;
            bus.px_data = p;
            bus.start   = spam_start && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                x  = b % KW;
                y  = (b / KW) % KW;
                px = (b / (KW * KW)) % FW;
                py = b / (KW * KW * FW);
                if (x == 0 && y == 0) part = 0;
                part += dot(w, p);
                if (x == KW - 1 && y == KW - 1) begin
                    exp_q.push_back({FCW'(px), FCW'(py), ACCW'(part)});
                    exp_cyc_q.push_back(cyc + 3);
                end
                b++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    // Keeps in_valid and start high through DRAIN (both must be ignored),
    // including the finish cycle, then checks the return to IDLE.
    task automatic finish_frame(input bit chk_const, input logic signed [ACCW-1:0] const_acc);
        bit seen;
        logic [CH*DW-1:0] w, p;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            gen_data(3, w, p);
            bus.w_data   = w;
            bus.px_data  = p;
            bus.in_valid = 1'b1;
            bus.start    = 1'b1;
            @(posedge clk); #1;
            if (bus.finish) seen = 1'b1;
        end
        check("finish_seen", seen, 1'b1);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("busy_after_finish", bus.busy, 1'b0);
        check("state_after_finish", bus.state, ST_IDLE);
        check("frame_out_count", out_cnt, FRAME_OUTS);
        if (chk_const) check("frame_acc_value", bus.acc_out, const_acc);
        repeat (3) @(posedge clk);
        #1;
        check("start_at_finish_ignored", bus.state, ST_IDLE);
    endtask

    task automatic apply_reset();
        xrst         = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        last_acc = '0;
        last_x   = '0;
        last_y   = '0;
        #2;
        check("rst_state", bus.state, ST_IDLE);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_finish", bus.finish, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_acc_out", bus.acc_out, '0);
        check("rst_out_X", bus.out_X, '0);
        check("rst_out_Y", bus.out_Y, '0);
        @(posedge clk);
        @(posedge clk); #1;
        xrst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    logic [CH*DW-1:0] iw, ip;

    initial begin
        xrst         = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.w_data   = '0;
        bus.px_data  = '0;

        @(posedge clk); #1;
        apply_reset();

        // in_valid while IDLE must be dropped
        repeat (20) begin
            gen_data(3, iw, ip);
            bus.w_data   = iw;
            bus.px_data  = ip;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("idle_in_valid_state", bus.state, ST_IDLE);
        check("idle_in_valid_busy", bus.busy, 1'b0);

        // all ones, no gaps, stray starts during RUN
        drive_beats(0, 0, FRAME_BEATS, 1'b1);
        finish_frame(1'b1, 24'sd144);

        // extreme values
        drive_beats(1, 0, FRAME_BEATS, 1'b0);
        finish_frame(1'b1, 24'sd2359296);
        drive_beats(2, 0, FRAME_BEATS, 1'b0);
        finish_frame(1'b1, -24'sd2340864);

        // random data with ~30% gaps
        drive_beats(3, 30, FRAME_BEATS, 1'b1);
        finish_frame(1'b0, '0);

        // reset after 1000 beats, then a clean frame
        drive_beats(3, 30, 1000, 1'b0);
        apply_reset();
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_state", bus.state, ST_IDLE);
        check("post_reset_busy", bus.busy, 1'b0);
        drive_beats(3, 30, FRAME_BEATS, 1'b0);
        finish_frame(1'b0, '0);

        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_mac.md
CONV_MAC -- requirements
Module: conv_mac

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge
- xrst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a 19x19 output frame
- in_valid  in  1  w_data/px_data beat present this cycle
- w_data  in  128  16 signed 8-bit kernel weights, channel c at bits [8c+7:8c]
- px_data  in  128  16 signed 8-bit pixels, same channel packing
- out_valid  out  1  acc_out holds one complete 3x3x16 sum this cycle
- acc_out  out  24  signed convolution result
- out_X, out_Y  out  5 each  output position of acc_out, 0..18
- busy  out  1  high in RUN and DRAIN
- finish  out  1  one-cycle pulse with the last frame output

Function
REQ-002 SHALL implement the states IDLE, RUN and DRAIN.
- IDLE->RUN on start.
- RUN->DRAIN on acceptance of the final beat.
- DRAIN->IDLE when the final result is emitted.
REQ-003 SHALL accept a beat only in RUN with in_valid=1; in_valid in IDLE or DRAIN SHALL be ignored.
REQ-004 SHALL ignore start outside IDLE.
REQ-005 SHALL keep beat counters x,y (0..2) and X,Y (0..18) in that order:
- x is innermost; x wraps 2->0 and carries to y.
- y wrap carries to X; X wrap carries to Y.
- Counters advance only on accepted beats and hold during in_valid gaps.
REQ-006 SHALL load counters to 0 on start; one frame is 3249 beats and 361 outputs.
REQ-007 Pipeline stage 1 SHALL register the 16 products w*px, each 16-bit signed, full precision.
REQ-008 Pipeline stage 2 SHALL register the signed sum of the 16 products, 20 bits.
REQ-009 Pipeline stage 3 SHALL form the 24-bit accumulator:
- Load the stage-2 sum when the tagged beat had x=0 and y=0.
- Otherwise add the stage-2 sum to the accumulator.
- No saturation is needed, because the worst case of 9*16*16384 = 2,359,296 fits in 24 bits.
REQ-010 SHALL carry valid, the first-tap flag, the last-tap flag and X/Y tags alongside the data, so that in_valid gaps never corrupt sums.
REQ-011 SHALL assert out_valid for one cycle exactly 3 cycles after the beat with x=2,y=2 is accepted, with out_X/out_Y equal to that beat's X/Y.
REQ-012 finish SHALL pulse together with out_valid for X=18,Y=18, and the state SHALL enter IDLE on the next edge.
REQ-013 acc_out, out_X and out_Y SHALL hold their last value when out_valid=0.
REQ-014 A start in the same cycle the state returns to IDLE SHALL be ignored; start is honoured only once the state reads IDLE.

Reset
REQ-015 xrst=0 SHALL asynchronously clear all state:
- State returns to IDLE.
- All counters, pipeline registers, valids, acc_out, out_X/out_Y, busy and finish go to 0.
REQ-016 Reset mid-frame SHALL discard in-flight beats, and no out_valid or finish SHALL follow until a new start.

Structure
REQ-017 Shared package conv_pkg SHALL hold:
- the constants KW=3, FW=19, CH=16, DW=8 and ACCW=24;
- the state enum.
REQ-018 SHALL instantiate one reusable modulo counter sub-module, count_n, parameterised by modulus, with q, max, enable, clk and xrst ports.
REQ-019 The counter chain SHALL be four count_n instances (moduli 3, 3, 19, 19); products and the adder tree SHALL stay inline.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Constant data, no gaps: start, all weights=1, all pixels=1, 3249 beats -> 361 out_valid pulses, each acc_out=144, out_X/out_Y sequence (0,0)..(18,18), finish with the last.
- Extreme values: all w=-128, all px=-128 -> acc_out=2,359,296 with no wrap; w=-128, px=127 -> acc_out=-2,340,864.
- Random in_valid gaps (~30% idle), random data -> acc_out matches the reference model per position, with latency measured from the x=2,y=2 beat of exactly 3 cycles.
- Illegal inputs: in_valid in IDLE and start during RUN -> ignored, and counters and outputs are unchanged.
- Mid-frame reset: xrst low after 1000 beats -> all outputs 0 and state IDLE; then a new start and a full frame -> correct 361 results.
- finish timing: finish high only in the cycle of the X=18,Y=18 result; busy falls on the next edge.
